// File: rtl/led_blink_sched_if.sv
// Command channel of the LED scheduler: mode/half-period/count with valid/ready.
// The master drives the command fields and CMD_VALID; the slave answers with CMD_READY.
interface led_blink_sched_if #(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 8
);
  logic               CMD_VALID;
  logic               CMD_READY;
  logic [1:0]         CMD_MODE;
  logic [CNT_W-1:0]   CMD_HALF;
  logic [BURST_W-1:0] CMD_COUNT;

  modport master (
    output CMD_VALID, CMD_MODE, CMD_HALF, CMD_COUNT,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_MODE, CMD_HALF, CMD_COUNT,
    output CMD_READY
  );
endinterface

// File: rtl/led_blink_sched.sv
// LED scheduler: off / on / continuous blink / N-blink burst; new state visible 1 edge after accept.
// Backpressure: CMD_READY is low only while a burst runs; held commands are taken once it ends.
module led_blink_sched #(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  led_blink_sched_if.slave    cmd,
  output logic                LED,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [1:0] {S_OFF, S_ON, S_BLK_HI, S_BLK_LO} state_t;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;
  logic [CNT_W-1:0]   half_eff;
  logic               accept;

  // busy_q doubles as the burst-mode flag: continuous blink never sets it
  assign cmd.CMD_READY = ~busy_q;
  assign accept        = cmd.CMD_VALID & ~busy_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    half_eff = (cmd.CMD_HALF == '0) ? CNT_W'(1) : cmd.CMD_HALF;

    if (accept) begin
      half_d = half_eff;
      rem_d  = cmd.CMD_COUNT;
      cnt_d  = half_eff - CNT_W'(1);
      busy_d = 1'b0;
      case (cmd.CMD_MODE)
        M_OFF:   state_d = S_OFF;
        M_ON:    state_d = S_ON;
        M_BLINK: state_d = S_BLK_HI;
        default: begin
          if (cmd.CMD_COUNT == '0) begin
            state_d = S_OFF;
            done_d  = 1'b1;
          end else begin
            state_d = S_BLK_HI;
            busy_d  = 1'b1;
          end
        end
      endcase
    end else if (state_q == S_BLK_HI || state_q == S_BLK_LO) begin
      if (cnt_q == '0) begin
        cnt_d = half_q - CNT_W'(1);
        if (state_q == S_BLK_HI) begin
          state_d = S_BLK_LO;
        end else if (busy_q) begin
          // one blink = one HI+LO pair; the burst ends when the last LO expires
          if (rem_q == BURST_W'(1)) begin
            state_d = S_OFF;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rem_d   = '0;
          end else begin
            rem_d   = rem_q - BURST_W'(1);
            state_d = S_BLK_HI;
          end
        end else begin
          state_d = S_BLK_HI;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign led_d = (state_d == S_ON) || (state_d == S_BLK_HI);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      half_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign LED  = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
